// File: rtl/esc_pwm_generator_pkg.sv
// Shared widths, ESC timing defaults and arming-state encoding for the ESC PWM generator.
package esc_pwm_generator_pkg;

    localparam int MOTOR_RATE_BIT_WIDTH = 8;
    localparam int MOTOR_RATE_MAX       = (1 << MOTOR_RATE_BIT_WIDTH) - 1;

    localparam int ESC_FRAME_TICKS     = 95000;
    localparam int ESC_MIN_PULSE_TICKS = 38000;
    localparam int ESC_STEP_TICKS      = 149;
    localparam int ESC_ARM_FRAMES      = 400;

    typedef enum logic {
        ST_DISARMED = 1'b0,
        ST_ARMED    = 1'b1
    } arm_state_t;

endpackage

// File: rtl/esc_pwm_channel.sv
// One ESC output: latches the pulse width at the frame boundary and compares it against the shared frame counter.
module esc_pwm_channel
    import esc_pwm_generator_pkg::*;
#(
    parameter int CNT_WIDTH       = 17,
    parameter int MIN_PULSE_TICKS = ESC_MIN_PULSE_TICKS,
    parameter int STEP_TICKS      = ESC_STEP_TICKS
) (
    input  logic                            sys_clk,
    input  logic                            reset,
    input  logic [CNT_WIDTH-1:0]            frame_cnt,
    input  logic                            latch,
    input  logic [MOTOR_RATE_BIT_WIDTH-1:0] rate,
    output logic                            pwm
);

    localparam logic [CNT_WIDTH-1:0] MIN_W  = CNT_WIDTH'(MIN_PULSE_TICKS);
    localparam logic [CNT_WIDTH-1:0] STEP_W = CNT_WIDTH'(STEP_TICKS);

    logic [CNT_WIDTH-1:0] pulse_ticks;

    always_ff @(posedge sys_clk) begin
        if (reset) begin
            pulse_ticks <= MIN_W;
            pwm         <= 1'b0;
        end else begin
            if (latch) begin
                pulse_ticks <= MIN_W + CNT_WIDTH'(rate) * STEP_W;
            end
            pwm <= (frame_cnt < pulse_ticks);
        end
    end

endmodule

// File: rtl/esc_pwm_generator.sv
// Four-channel fixed-frame ESC pulse generator with an arming sequencer that holds
// all outputs at minimum pulse until enable has been stable for ARM_FRAMES frames.
module esc_pwm_generator
    import esc_pwm_generator_pkg::*;
#(
    parameter int FRAME_TICKS     = ESC_FRAME_TICKS,
    parameter int MIN_PULSE_TICKS = ESC_MIN_PULSE_TICKS,
    parameter int STEP_TICKS      = ESC_STEP_TICKS,
    parameter int ARM_FRAMES      = ESC_ARM_FRAMES
) (
    input  logic                            sys_clk,
    input  logic                            reset,
    input  logic                            enable,
    input  logic [MOTOR_RATE_BIT_WIDTH-1:0] motor_1_rate,
    input  logic [MOTOR_RATE_BIT_WIDTH-1:0] motor_2_rate,
    input  logic [MOTOR_RATE_BIT_WIDTH-1:0] motor_3_rate,
    input  logic [MOTOR_RATE_BIT_WIDTH-1:0] motor_4_rate,
    output logic                            motor_1_pwm,
    output logic                            motor_2_pwm,
    output logic                            motor_3_pwm,
    output logic                            motor_4_pwm,
    output logic                            frame_start,
    output logic                            armed
);

    localparam int CNT_WIDTH = $clog2(FRAME_TICKS);
    localparam int ARM_WIDTH = $clog2(ARM_FRAMES + 1);
    localparam logic [CNT_WIDTH-1:0] LAST_TICK = CNT_WIDTH'(FRAME_TICKS - 1);
    localparam logic [ARM_WIDTH-1:0] ARM_LAST  = ARM_WIDTH'(ARM_FRAMES - 1);

    if ((MIN_PULSE_TICKS + MOTOR_RATE_MAX * STEP_TICKS >= FRAME_TICKS) || (ARM_FRAMES < 1)) begin : g_bad_params
        $error("esc_pwm_generator: longest pulse must fit inside the frame and ARM_FRAMES must be >= 1");
    end

    logic [CNT_WIDTH-1:0]            frame_cnt;
    logic [ARM_WIDTH-1:0]            arm_cnt;
    arm_state_t                      state;
    logic                            latch;
    logic                            arm_next;
    logic [MOTOR_RATE_BIT_WIDTH-1:0] rates     [4];
    logic [MOTOR_RATE_BIT_WIDTH-1:0] eff_rates [4];
    logic [3:0]                      pwms;

    assign latch = (frame_cnt == LAST_TICK);

    assign rates[0] = motor_1_rate;
    assign rates[1] = motor_2_rate;
    assign rates[2] = motor_3_rate;
    assign rates[3] = motor_4_rate;

    // Next-state decision is combinational so the latch cycle that completes arming
    // already loads real rates: frame ARM_FRAMES+1 is the first to carry them.
    always_comb begin
        arm_next = 1'b0;
        unique case (state)
            ST_ARMED:    arm_next = enable;
            ST_DISARMED: arm_next = enable && latch && (arm_cnt == ARM_LAST);
            default:     arm_next = 1'b0;
        endcase
    end

    always_comb begin
        for (int unsigned i = 0; i < 4; i++) begin
            eff_rates[i] = arm_next ? rates[i] : '0;
        end
    end

    always_ff @(posedge sys_clk) begin
        if (reset) begin
            frame_cnt   <= '0;
            frame_start <= 1'b0;
            arm_cnt     <= '0;
            state       <= ST_DISARMED;
            armed       <= 1'b0;
        end else begin
            frame_cnt   <= latch ? '0 : frame_cnt + 1'b1;
            frame_start <= (frame_cnt == '0);
            if (!enable) begin
                arm_cnt <= '0;
            end else if ((state == ST_DISARMED) && latch) begin
                arm_cnt <= arm_cnt + 1'b1;
            end
            state <= arm_next ? ST_ARMED : ST_DISARMED;
            armed <= arm_next;
        end
    end

    for (genvar i = 0; i < 4; i++) begin : g_channel
        esc_pwm_channel #(
            .CNT_WIDTH      (CNT_WIDTH),
            .MIN_PULSE_TICKS(MIN_PULSE_TICKS),
            .STEP_TICKS     (STEP_TICKS)
        ) u_channel (
            .sys_clk  (sys_clk),
            .reset    (reset),
            .frame_cnt(frame_cnt),
            .latch    (latch),
            .rate     (eff_rates[i]),
            .pwm      (pwms[i])
        );
    end

    assign motor_1_pwm = pwms[0];
    assign motor_2_pwm = pwms[1];
    assign motor_3_pwm = pwms[2];
    assign motor_4_pwm = pwms[3];

endmodule

// File: tb/tb_esc_pwm_generator.sv
// Bench for esc_pwm_generator: directed arming/disarm/reset scenarios plus randomized rates,
// checked every cycle against a time-arithmetic reference model.
module tb_esc_pwm_generator;

    localparam int FT   = 1000;
    localparam int MINP = 200;
    localparam int STEP = 2;
    localparam int ARM  = 3;

    logic       sys_clk = 1'b0;
    logic       reset   = 1'b1;
    logic       enable  = 1'b0;
    logic [7:0] rate [4];
    logic       motor_1_pwm, motor_2_pwm, motor_3_pwm, motor_4_pwm;
    logic       frame_start, armed;

    int vectors     = 0;
    int miscompares = 0;

    // Reference model state: k = edges since reset release, last_low = last edge with enable low.
    int         k          = 0;
    int         last_low   = 0;
    int         edge_total = 0;
    int         last_fs    = -1;
    int         cur_w [4]  = '{MINP, MINP, MINP, MINP};
    int         nxt_w [4]  = '{MINP, MINP, MINP, MINP};
    logic       exp_armed  = 1'b0;
    logic [5:0] exp_out    = '0;

    logic [3:0] prev_pw    = '0;
    int         hi_cnt [4] = '{0, 0, 0, 0};
    int         meas_w [4] = '{0, 0, 0, 0};

    always #5 sys_clk = ~sys_clk;

    esc_pwm_generator #(
        .FRAME_TICKS    (FT),
        .MIN_PULSE_TICKS(MINP),
        .STEP_TICKS     (STEP),
        .ARM_FRAMES     (ARM)
    ) dut (
        .sys_clk     (sys_clk),
        .reset       (reset),
        .enable      (enable),
        .motor_1_rate(rate[0]),
        .motor_2_rate(rate[1]),
        .motor_3_rate(rate[2]),
        .motor_4_rate(rate[3]),
        .motor_1_pwm (motor_1_pwm),
        .motor_2_pwm (motor_2_pwm),
        .motor_3_pwm (motor_3_pwm),
        .motor_4_pwm (motor_4_pwm),
        .frame_start (frame_start),
        .armed       (armed)
    );

    // Armed once ARM frame boundaries (multiples of FT) have passed since enable was last low.
    task automatic model_edge();
        int p;
        edge_total++;
        if (reset) begin
            k        = 0;
            last_low = 0;
            last_fs  = -1;
            exp_out  = '0;
            for (int i = 0; i < 4; i++) nxt_w[i] = MINP;
        end else begin
            k++;
            if (!enable) last_low = k;
            exp_armed = enable && ((k / FT - last_low / FT) >= ARM);
            p = (k - 1) % FT;
            if (p == 0) cur_w = nxt_w;
            if (k % FT == 0) begin
                for (int i = 0; i < 4; i++) nxt_w[i] = MINP + (exp_armed ? int'(rate[i]) : 0) * STEP;
            end
            for (int i = 0; i < 4; i++) exp_out[i] = (p < cur_w[i]);
            exp_out[4] = (p == 0);
            exp_out[5] = exp_armed;
        end
    endtask

    task automatic sample();
        logic [3:0] pw;
        logic [5:0] got;
        pw  = {motor_4_pwm, motor_3_pwm, motor_2_pwm, motor_1_pwm};
        got = {armed, frame_start, pw};
        vectors++;
        assert (got === exp_out) else begin
            miscompares++;
            $error("FAIL outputs k=%0d got=%b expected=%b", k, got, exp_out);
        end
        if (frame_start === 1'b1) begin
            if (last_fs >= 0) begin
                vectors++;
                assert (edge_total - last_fs == FT) else begin
                    miscompares++;
                    $error("FAIL frame_spacing k=%0d got=%0d expected=%0d", k, edge_total - last_fs, FT);
                end
            end
            last_fs = edge_total;
        end
        for (int i = 0; i < 4; i++) begin
            if (pw[i] === 1'b1 && prev_pw[i] === 1'b0) begin
                vectors++;
                assert (frame_start === 1'b1) else begin
                    miscompares++;
                    $error("FAIL rise_vs_frame_start ch=%0d k=%0d got=%b expected=1", i + 1, k, frame_start);
                end
            end
            if (pw[i] === 1'b1) begin
                hi_cnt[i]++;
            end else if (prev_pw[i] === 1'b1) begin
                meas_w[i] = hi_cnt[i];
                hi_cnt[i] = 0;
            end
        end
        prev_pw = pw;
    endtask

    task automatic cycle();
        @(posedge sys_clk);
        model_edge();
        @(negedge sys_clk);
        sample();
    endtask

    task automatic run_to(input int target);
        for (int n = 0; n < 20000 && k != target; n++) cycle();
        vectors++;
        assert (k == target) else begin
            miscompares++;
            $error("FAIL run_to_timeout got=%0d expected=%0d", k, target);
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] expv);
        vectors++;
        assert (got === expv) else begin
            miscompares++;
            $error("FAIL %s got=%0d expected=%0d", tag, got, expv);
        end
    endtask

    task automatic chk_widths(input string tag, input int w1, input int w2, input int w3, input int w4);
        chk({tag, "_w1"}, meas_w[0], w1);
        chk({tag, "_w2"}, meas_w[1], w2);
        chk({tag, "_w3"}, meas_w[2], w3);
        chk({tag, "_w4"}, meas_w[3], w4);
    endtask

    function automatic logic [7:0] rand_rate();
        if ($urandom_range(0, 3) == 0) return ($urandom_range(0, 1) == 1) ? 8'd255 : 8'd0;
        return 8'($urandom_range(0, 255));
    endfunction

    initial begin
        int  pos, gpos, glen, ph;
        bit  glitch;

        // Disarmed: enable low, full-scale rates must still give minimum pulses.
        for (int i = 0; i < 4; i++) rate[i] = 8'd255;
        reset = 1'b1; enable = 1'b0;
        repeat (3) cycle();
        chk("reset_armed", armed, 0);
        chk("reset_frame_start", frame_start, 0);
        reset = 1'b0;
        cycle();
        chk("first_rise_pwm1", motor_1_pwm, 1);
        chk("first_frame_start", frame_start, 1);
        run_to(1800);
        chk_widths("disarmed_f2", MINP, MINP, MINP, MINP);
        chk("disarmed_armed", armed, 0);

        // Arming from reset with enable held high.
        reset = 1'b1; enable = 1'b1;
        rate[0] = 8'd0; rate[1] = 8'd100; rate[2] = 8'd200; rate[3] = 8'd255;
        repeat (2) cycle();
        reset = 1'b0;
        run_to(2800);
        chk_widths("arming_f3", 200, 200, 200, 200);
        run_to(2999);
        chk("armed_before_3rd", armed, 0);
        cycle();
        chk("armed_after_3rd", armed, 1);
        run_to(3800);
        chk_widths("armed_f4", 200, 400, 600, 710);

        // Mid-frame rate change on motor 1.
        rate[0] = 8'd10;
        run_to(4300);
        rate[0] = 8'd50;
        run_to(4800);
        chk("midframe_cur_w1", meas_w[0], 220);
        run_to(5800);
        chk("midframe_next_w1", meas_w[0], 300);

        // Disarm mid-frame, then re-enable.
        run_to(6500);
        chk("armed_before_drop", armed, 1);
        enable = 1'b0;
        cycle();
        chk("armed_after_drop", armed, 0);
        run_to(6800);
        chk_widths("disarm_cur", 300, 400, 600, 710);
        run_to(7500);
        enable = 1'b1;
        run_to(7800);
        chk_widths("disarm_next", 200, 200, 200, 200);
        run_to(9999);
        chk("rearm_before", armed, 0);
        cycle();
        chk("rearm_after", armed, 1);

        // Reset mid-pulse.
        run_to(10150);
        reset = 1'b1;
        cycle();
        chk("reset_mid_pwm", {motor_4_pwm, motor_3_pwm, motor_2_pwm, motor_1_pwm}, 0);
        chk("reset_mid_armed", armed, 0);
        repeat (2) cycle();
        reset = 1'b0;
        cycle();
        chk("post_reset_rise", {motor_4_pwm, motor_3_pwm, motor_2_pwm, motor_1_pwm}, 4'hF);
        run_to(1800);
        chk_widths("post_reset_f2", 200, 200, 200, 200);
        chk("post_reset_armed", armed, 0);

        // Randomized rates and short enable glitches, checked every cycle by the model.
        for (int f = 0; f < 10; f++) begin
            pos    = $urandom_range(0, FT - 1);
            glitch = ($urandom_range(0, 3) == 0);
            gpos   = $urandom_range(0, FT - 4);
            glen   = $urandom_range(1, 3);
            for (int c = 0; c < FT; c++) begin
                ph = k % FT;
                if (ph == pos) begin
                    for (int i = 0; i < 4; i++) rate[i] = rand_rate();
                end
                enable = !(glitch && ph >= gpos && ph < gpos + glen);
                cycle();
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
